// File: rtl/fake_mario_pio_in_if.sv
// Avalon-MM slave bus bundle for fake_mario_pio_in: CPU-side register access signals.
interface fake_mario_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/fake_mario_pio_in.sv
// Parametrised Avalon-MM input port: optional synchronizer, per-bit edge capture
// with write-1-to-clear, and a maskable level interrupt.
module fake_mario_pio_in #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fake_mario_pio_in_if.slave    bus,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    typedef enum logic {
        WARMUP,
        ARMED
    } arm_state_t;

    localparam int unsigned CNT_W = 3;

    arm_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  armed;

    logic [DATA_WIDTH-1:0] sync;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] edge_vec;
    logic [DATA_WIDTH-1:0] irqmask;
    logic [DATA_WIDTH-1:0] edgecapture;
    logic [DATA_WIDTH-1:0] clr;
    logic [31:0]           rd_next;
    logic                  wr;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync = in_port;
        end else begin : g_sync
            logic [DATA_WIDTH-1:0] s [SYNC_STAGES];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                        s[k] <= '0;
                    end
                end else begin
                    s[0] <= in_port;
                    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                        s[k] <= s[k-1];
                    end
                end
            end

            assign sync = s[SYNC_STAGES-1];
        end
    endgenerate

    // Warm-up keeps edges masked until the sync/prev pipeline holds real input,
    // so a level already high at reset release is not taken for an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WARMUP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed   = (state_q == ARMED);
        if (state_q == WARMUP) begin
            if (cnt_q == CNT_W'(SYNC_STAGES)) begin
                state_d = ARMED;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_vec = sync & ~prev;
        end else if (EDGE_TYPE == 1) begin
            edge_vec = ~sync & prev;
        end else begin
            edge_vec = sync ^ prev;
        end
    end

    assign wr  = bus.chipselect & ~bus.write_n;
    assign clr = (wr && bus.address == 2'd3) ? bus.writedata[DATA_WIDTH-1:0] : '0;

    always_comb begin
        rd_next = '0;
        case (bus.address)
            2'd0:    rd_next[DATA_WIDTH-1:0] = sync;
            2'd2:    rd_next[DATA_WIDTH-1:0] = irqmask;
            2'd3:    rd_next[DATA_WIDTH-1:0] = edgecapture;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= '0;
            irqmask      <= '0;
            edgecapture  <= '0;
            bus.readdata <= '0;
        end else begin
            prev <= sync;
            if (wr && bus.address == 2'd2) begin
                irqmask <= bus.writedata[DATA_WIDTH-1:0];
            end
            // OR-ing the new edge after the clear makes a same-cycle edge win.
            edgecapture  <= (edgecapture & ~clr) | (edge_vec & {DATA_WIDTH{armed}});
            bus.readdata <= rd_next;
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_fake_mario_pio_in.sv
// Scoreboard bench for fake_mario_pio_in: a 32-bit rising-edge instance and an
// 8-bit any-change instance driven by directed bus/input vectors.
module tb_fake_mario_pio_in;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fake_mario_pio_in_if b0 ();
    fake_mario_pio_in_if b1 ();

    logic [31:0] in0;
    logic [7:0]  in1;
    logic        irq0, irq1;

    fake_mario_pio_in #(.DATA_WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0)) u0 (
        .clk(clk), .reset_n(reset_n), .bus(b0.slave), .in_port(in0), .irq(irq0)
    );

    fake_mario_pio_in #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2)) u1 (
        .clk(clk), .reset_n(reset_n), .bus(b1.slave), .in_port(in1), .irq(irq1)
    );

    typedef struct {
        string       name;
        bit          d;
        bit          chk_rd;
        logic [31:0] rd;
        bit          chk_irq;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    bit   req = 1'b0;
    bit   vld = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) vld <= req;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] rd;
        logic        ir;
        if (vld) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got output with no expectation, required one queued");
            end else begin
                e  = sb.pop_front();
                rd = e.d ? b1.readdata : b0.readdata;
                ir = e.d ? irq1 : irq0;
                if (e.chk_rd) begin
                    n_checks++;
                    if (rd !== e.rd) begin
                        n_fail++;
                        $display("FAIL %s readdata: got %h, required %h", e.name, rd, e.rd);
                    end
                end
                if (e.chk_irq) begin
                    n_checks++;
                    if (ir !== e.irq) begin
                        n_fail++;
                        $display("FAIL %s irq: got %b, required %b", e.name, ir, e.irq);
                    end
                end
            end
        end
    end

    task automatic bus_idle();
        b0.chipselect = 1'b0; b0.write_n = 1'b1;
        b1.chipselect = 1'b0; b1.write_n = 1'b1;
    endtask

    task automatic op(input bit d, input bit w, input logic [1:0] a, input logic [31:0] wd,
                      input string name, input bit chk_rd, input logic [31:0] erd,
                      input bit chk_irq, input logic eirq);
        exp_t e;
        e.name = name; e.d = d; e.chk_rd = chk_rd; e.rd = erd;
        e.chk_irq = chk_irq; e.irq = eirq;
        sb.push_back(e);
        if (d) begin
            b1.address = a; b1.chipselect = w; b1.write_n = ~w; b1.writedata = wd;
        end else begin
            b0.address = a; b0.chipselect = w; b0.write_n = ~w; b0.writedata = wd;
        end
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        bus_idle();
    endtask

    task automatic do_rd(input bit d, input logic [1:0] a, input logic [31:0] erd, input string name);
        op(d, 1'b0, a, 32'h0, name, 1'b1, erd, 1'b0, 1'b0);
    endtask

    task automatic do_rdi(input bit d, input logic [1:0] a, input logic [31:0] erd,
                          input logic eirq, input string name);
        op(d, 1'b0, a, 32'h0, name, 1'b1, erd, 1'b1, eirq);
    endtask

    task automatic do_wr(input bit d, input logic [1:0] a, input logic [31:0] wd,
                         input logic eirq, input string name);
        op(d, 1'b1, a, wd, name, 1'b0, 32'h0, 1'b1, eirq);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        b0.address = '0; b0.writedata = '0;
        b1.address = '0; b1.writedata = '0;
        bus_idle();
        reset_n = 1'b0;
        in0 = 32'hFFFF_FFFF;
        in1 = 8'h00;
        @(negedge clk);

        // Reset state
        do_rdi(0, 2'd0, 32'h0, 1'b0, "rst_data0");
        do_rdi(1, 2'd0, 32'h0, 1'b0, "rst_data1");
        do_rdi(0, 2'd3, 32'h0, 1'b0, "rst_cap0");
        reset_n = 1'b1;

        // Input high through reset must not capture
        for (int i = 0; i < 6; i++) do_rdi(0, 2'd3, 32'h0, 1'b0, "warmup_cap");
        do_rd(0, 2'd0, 32'hFFFF_FFFF, "data_ones");
        do_wr(0, 2'd2, 32'hFFFF_FFFF, 1'b0, "mask_all");
        do_rdi(0, 2'd2, 32'hFFFF_FFFF, 1'b0, "mask_all_rb");
        do_rdi(0, 2'd3, 32'h0, 1'b0, "cap_after_warmup");

        // Rising edge on bit 3, latency through two sync stages
        do_wr(0, 2'd2, 32'h8, 1'b0, "mask8");
        in0 = 32'h0;
        idle(4);
        do_rdi(0, 2'd3, 32'h0, 1'b0, "falling_ignored");
        in0 = 32'h8;
        do_rdi(0, 2'd3, 32'h0, 1'b0, "lat_e0");
        do_rdi(0, 2'd3, 32'h0, 1'b0, "lat_e1");
        do_rdi(0, 2'd3, 32'h0, 1'b1, "lat_e2");
        do_rdi(0, 2'd3, 32'h8, 1'b1, "lat_e3");
        do_wr(0, 2'd3, 32'h8, 1'b0, "clr_bit3");
        do_rdi(0, 2'd3, 32'h0, 1'b0, "cap_cleared");

        // Capture while masked, then unmask
        do_wr(0, 2'd2, 32'h0, 1'b0, "mask0");
        in0 = 32'h0;
        idle(3);
        in0 = 32'h8;
        idle(3);
        do_rdi(0, 2'd3, 32'h8, 1'b0, "cap_masked");
        do_wr(0, 2'd2, 32'h8, 1'b1, "unmask_irq");
        do_rdi(0, 2'd2, 32'h8, 1'b1, "mask8_rb");

        // Clear and new edge on bit 0 in the same cycle
        do_wr(0, 2'd3, 32'h8, 1'b0, "clr_b3");
        do_wr(0, 2'd2, 32'h1, 1'b0, "mask1");
        in0 = 32'h9;
        idle(2);
        do_wr(0, 2'd3, 32'h1, 1'b1, "clr_vs_edge");
        do_rdi(0, 2'd3, 32'h1, 1'b1, "edge_wins");
        do_rd(0, 2'd0, 32'h9, "data9");

        // Writes to read-only / reserved addresses
        do_wr(0, 2'd0, 32'hDEAD_BEEF, 1'b1, "wr_a0");
        do_wr(0, 2'd1, 32'hDEAD_BEEF, 1'b1, "wr_a1");
        do_rdi(0, 2'd0, 32'h9, 1'b1, "a0_unchanged");
        do_rdi(0, 2'd1, 32'h0, 1'b1, "a1_zero");

        // 8-bit any-change instance
        in1 = 8'h5A;
        idle(3);
        do_rdi(1, 2'd3, 32'h5A, 1'b0, "any_rise");
        do_wr(1, 2'd3, 32'hFFFF_FFFF, 1'b0, "clr1");
        in1 = 8'h00;
        idle(3);
        do_rdi(1, 2'd3, 32'h5A, 1'b0, "any_fall");
        do_wr(1, 2'd2, 32'hFFFF_FFFF, 1'b1, "mask_ff");
        do_rdi(1, 2'd2, 32'h0000_00FF, 1'b1, "mask_ff_rb");
        do_rd(1, 2'd0, 32'h0, "data1");

        // Reset asserted in the middle of a mask write
        b0.address = 2'd2; b0.chipselect = 1'b1; b0.write_n = 1'b0; b0.writedata = 32'hDEAD_BEEF;
        #2 reset_n = 1'b0;
        @(negedge clk);
        bus_idle();
        do_rdi(0, 2'd2, 32'h0, 1'b0, "rst_mid_0");
        do_rdi(1, 2'd3, 32'h0, 1'b0, "rst_mid_1");
        reset_n = 1'b1;
        idle(5);
        do_rdi(0, 2'd2, 32'h0, 1'b0, "mask_after_rst");
        do_rdi(0, 2'd3, 32'h0, 1'b0, "cap_after_rst");
        do_rdi(0, 2'd0, 32'h9, 1'b0, "data_after_rst");
        do_rdi(1, 2'd2, 32'h0, 1'b0, "mask1_after_rst");

        idle(3);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fake_mario_pio_in.md
# fake_mario_pio_in

Parametrised Avalon-MM input port with optional synchronizer, per-bit edge capture and a maskable interrupt. Generalises the plain 32-bit input port: any width, a selectable edge type, write-1-to-clear capture bits and a level IRQ to the Nios II. It sits on the system interconnect between off-chip or fabric-side status signals (buttons, game-state flags, position words) and the CPU data master.

## Interface
- DATA_WIDTH, 32 — width of in_port, the data register, the mask and the capture register; legal range 1..32.
- SYNC_STAGES, 2 — number of flip-flops on in_port before use; 0 means in_port is used directly (same-clock source), legal range 0..4.
- EDGE_TYPE, 0 — capture condition: 0 rising, 1 falling, 2 any change.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  word address of the register.
- chipselect  in  1  slave select; qualifies writes only.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above DATA_WIDTH are ignored.
- in_port  in  DATA_WIDTH  external input bits.
- readdata  out  32  registered read data; bits above DATA_WIDTH read 0.
- irq  out  1  level interrupt, high while any unmasked capture bit is set.

## Operation
- Synchronizer: s[0] <= in_port, s[k] <= s[k-1]. sync = s[SYNC_STAGES-1], or sync = in_port when SYNC_STAGES = 0. All stages reset to 0.
- prev <= sync every cycle; reset 0.
- Edge vector: rising = sync & ~prev; falling = ~sync & prev; any = sync ^ prev. EDGE_TYPE selects which one is used.
- Warm-up: a counter runs SYNC_STAGES+1 cycles after reset deassertion, then sets armed. Before armed, edges are ignored. This prevents an input that is already high at reset from producing a false capture.
- Write strobe: wr = chipselect & ~write_n.
- Register map (address):
  - 0 data: read returns sync. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 irqmask: read/write, DATA_WIDTH bits, reset 0.
  - 3 edgecapture: reads return the capture bits. A write clears every bit whose writedata bit is 1.
- Capture update: edgecapture <= (edgecapture & ~clr) | (edge & {armed}). clr is writedata when wr and address==3, otherwise 0.
- Simultaneous clear and new edge on the same bit: the edge wins, and the bit stays 1.
- irq = |(edgecapture & irqmask). It is driven only from registers, with no combinational path from bus inputs.
- readdata <= mux(address) on every clock, independent of chipselect.

## Timing
- Reset values: readdata 0, irq 0, irqmask 0, edgecapture 0, armed 0, all sync/prev flops 0.
- Read: fixed latency 1. Address presented before edge E gives readdata valid after E. No wait states.
- Write: takes effect at the edge on which wr is sampled. A read of the same register presented one cycle later returns the new value.
- Input path with SYNC_STAGES=2: in_port changes before edge E0.
  - sync updates at E1.
  - edgecapture sets at E2.
  - irq is high after E2, if the bit is masked in.
  - A data read presented before E2 returns the new value after E2.
- General input path: edgecapture sets SYNC_STAGES+1 edges after the input change (1 edge when SYNC_STAGES=0).
- Clear path: edgecapture clears at the write edge. irq falls in the same cycle if no other unmasked bit remains set.
- Mask changes affect irq immediately after the write edge.
- Pulses narrower than one clock may be missed. Stable levels never re-capture until cleared and a new edge occurs.
- Reset asserted mid-operation: all state returns to reset values asynchronously, and the warm-up repeats.

## Test plan
- Reset with in_port=32'hFFFF_FFFF held high, EDGE_TYPE=0 -> edgecapture reads 0 and irq stays 0 throughout; data read returns 32'hFFFF_FFFF.
- in_port bit 3 goes 0->1, irqmask=32'h8 -> edgecapture=32'h8 two edges later (SYNC_STAGES=2); irq=1; write 32'h8 to address 3 -> edgecapture=0 and irq=0 the next cycle.
- Same bit rising edge as in the previous scenario, but irqmask=0 -> edgecapture=32'h8, irq=0; then write irqmask=32'h8 -> irq=1 the next cycle.
- Clear write to bit 0 in the same cycle a new edge on bit 0 is captured -> bit 0 reads 1, irq remains asserted.
- EDGE_TYPE=2, DATA_WIDTH=8: in_port toggles 8'h00->8'h5A->8'h00 -> edgecapture=8'h5A after the first change and still 8'h5A after the second; readdata[31:8]=0.
- Write 32'hDEAD_BEEF to address 0 and address 1 -> data read is unchanged, address 1 reads 0; reset asserted mid-write -> all outputs 0.
